// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key schedule.
//   SBOX      : 256-entry forward S-box, indexed by the input byte
//   RCON      : round constants 01..36, entry k is used for round k+1
//   rot_word  : rotate a word one byte to the left
//   sub_word  : apply the S-box to each byte of a word
//   nw        : number of schedule words for nb/nr
//   ks_state_t: key-expansion FSM encoding
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[x[8*b +: 8]];
    return r;
  endfunction

  function automatic int nw(input int nb_words, input int nr_rounds);
    return nb_words * (nr_rounds + 1);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four S-box lookups on one 32-bit word, purely combinational.
// This is the only S-box hardware in the key schedule; the RotWord path and
// the 256-bit mid-block SubWord path share it through an input mux upstream.
//   word   : input word
//   subbed : S-box applied to every byte of word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  assign subbed = sub_word(word);

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one round-key word per clock for AES-128/192/256.
// Optional feature macro: AES_KEY_ZEROIZE_EN (adds the zeroize input).
//   clk, rst_n : clock, asynchronous active-low reset
//   zeroize    : (AES_KEY_ZEROIZE_EN only) one-cycle pulse clears w and returns to IDLE
//   in_key     : cipher key, word 0 in the MSBs; sampled only on the accept cycle
//   in_valid   : key present; in_ready: high only in IDLE
//   w          : flat schedule, word i at [W-1-32*i -: 32]
//   out_valid  : schedule complete and held; out_ready: consumer has taken w
//   busy       : high while expanding
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Input side: in_valid && in_ready accepts the key. Output side:
// out_valid && out_ready releases w; w is stable for the whole time out_valid is high.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nb = 4,
  parameter int nr = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic [32*nk-1:0]        in_key,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [32*nw(nb,nr)-1:0] w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int NW = nw(nb, nr);
  localparam int IW = $clog2(NW + 1);

  ks_state_t     state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [31:0]   w_q [NW];

  logic          zero_req;
  logic          load, step, last;
  logic [IW-1:0] idx_prev, idx_back;
  logic [31:0]   prev_word, sub_in, sub_out, t_word, new_word;
  logic [3:0]    rcon_sel;
  logic          is_rot, is_sub_only;
  int            i_mod, i_div;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign last = (idx_q == IW'(NW - 1));

  // Next-state / control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Zeroize overrides both the accept and the DONE handshake.
    if (zero_req) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  // Operand selection for word idx. Indices are clamped so the reads stay in
  // range while idx is outside EXPAND; the results are unused there.
  always_comb begin
    i_mod       = int'(idx_q) % nk;
    i_div       = int'(idx_q) / nk;
    rcon_sel    = (i_div >= 1 && i_div <= 10) ? 4'(i_div - 1) : 4'd0;
    idx_prev    = (idx_q != '0) ? idx_q - IW'(1) : '0;
    idx_back    = (int'(idx_q) >= nk) ? idx_q - IW'(nk) : '0;
    is_rot      = (i_mod == 0);
    is_sub_only = (nk == 8) && (i_mod == 4);
    prev_word   = w_q[idx_prev];
    sub_in      = is_rot ? rot_word(prev_word) : prev_word;
  end

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .subbed (sub_out)
  );

  always_comb begin
    t_word = prev_word;
    if (is_rot)           t_word = sub_out ^ {RCON[rcon_sel], 24'h0};
    else if (is_sub_only) t_word = sub_out;
    new_word = w_q[idx_back] ^ t_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      state_q <= state_d;
      if (zero_req) begin
        idx_q <= '0;
        for (int j = 0; j < NW; j++) w_q[j] <= '0;
      end else if (load) begin
        // Words beyond the key are cleared so unfinished words read 0.
        idx_q <= IW'(nk);
        for (int j = 0; j < NW; j++)
          w_q[j] <= (j < nk) ? in_key[32*nk-1-32*j -: 32] : 32'h0;
      end else if (step) begin
        w_q[idx_q] <= new_word;
        if (!last) idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EXPAND);
  assign out_valid = (state_q == ST_DONE);

  always_comb begin
    w = '0;
    for (int j = 0; j < NW; j++) w[32*NW-1-32*j -: 32] = w_q[j];
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: one instance each of AES-128/192/256
// sharing clock and reset, checked against FIPS-197 schedule words.
module tb_aes_key_expand_seq;

  localparam int NW128 = 44;
  localparam int NW192 = 52;
  localparam int NW256 = 60;

  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K3 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K4 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] k128 = '0;
  logic [191:0] k192 = '0;
  logic [255:0] k256 = '0;
  logic v128 = 1'b0, v192 = 1'b0, v256 = 1'b0;
  logic r128 = 1'b0, r192 = 1'b0, r256 = 1'b0;
  logic ir128, ir192, ir256, ov128, ov192, ov256, bz128, bz192, bz256;
  logic [32*NW128-1:0] w128;
  logic [32*NW192-1:0] w192;
  logic [32*NW256-1:0] w256;
`ifdef AES_KEY_ZEROIZE_EN
  logic z128 = 1'b0, z192 = 1'b0, z256 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int sel = 0;
  logic ir, ov, bz;

  aes_key_expand_seq #(.nk(4), .nb(4), .nr(10)) u128 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(z128),
`endif
    .in_key(k128), .in_valid(v128), .in_ready(ir128), .w(w128),
    .out_valid(ov128), .out_ready(r128), .busy(bz128));

  aes_key_expand_seq #(.nk(6), .nb(4), .nr(12)) u192 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(z192),
`endif
    .in_key(k192), .in_valid(v192), .in_ready(ir192), .w(w192),
    .out_valid(ov192), .out_ready(r192), .busy(bz192));

  aes_key_expand_seq #(.nk(8), .nb(4), .nr(14)) u256 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(z256),
`endif
    .in_key(k256), .in_valid(v256), .in_ready(ir256), .w(w256),
    .out_valid(ov256), .out_ready(r256), .busy(bz256));

  always_comb begin
    case (sel)
      0:       begin ir = ir128; ov = ov128; bz = bz128; end
      1:       begin ir = ir192; ov = ov192; bz = bz192; end
      default: begin ir = ir256; ov = ov256; bz = bz256; end
    endcase
  end

  function automatic logic [31:0] wword(input int s, input int i);
    case (s)
      0:       wword = w128[32*NW128-1-32*i -: 32];
      1:       wword = w192[32*NW192-1-32*i -: 32];
      default: wword = w256[32*NW256-1-32*i -: 32];
    endcase
  endfunction

  // driver: present key to instance s, count edges from accept until out_valid
  task automatic run_key(input int s, input logic [255:0] key, output int lat);
    sel = s;
    @(negedge clk);
    n_checks++;
    if (ir !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready inst%0d: in_ready=%b expected 1", s, ir);
    end
    k128 = key[255:128]; k192 = key[255:64]; k256 = key;
    case (s)
      0:       v128 = 1'b1;
      1:       v192 = 1'b1;
      default: v256 = 1'b1;
    endcase
    @(negedge clk);
    v128 = 1'b0; v192 = 1'b0; v256 = 1'b0;
    lat = 1;
    while (ov !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (ov !== 1'b1) begin
      n_fail++; $display("FAIL done_timeout inst%0d: out_valid=%b expected 1", s, ov);
    end
  endtask

  task automatic handshake(input int s);
    sel = s;
    @(negedge clk);
    case (s)
      0:       r128 = 1'b1;
      1:       r192 = 1'b1;
      default: r256 = 1'b1;
    endcase
    @(negedge clk);
    r128 = 1'b0; r192 = 1'b0; r256 = 1'b0;
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL release inst%0d: in_ready=%b out_valid=%b expected 1/0", s, ir, ov);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (w128 !== '0 || w192 !== '0 || w256 !== '0) begin
      n_fail++; $display("FAIL reset_w: w not zero (w128[43]=%h) expected 0", w128[31:0]);
    end
    n_checks++;
    if ({ov128, ov192, ov256, bz128, bz192, bz256} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: ov=%b%b%b busy=%b%b%b expected 0",
                         ov128, ov192, ov256, bz128, bz192, bz256);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ir128, ir192, ir256} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%b%b%b expected 111", ir128, ir192, ir256);
    end
  endtask

  task automatic test_aes128_a();
    int lat;
    int idx_t [6] = '{0, 4, 40, 41, 42, 43};
    logic [31:0] exp_t [6] = '{32'h00010203, 32'hd6aa74fd, 32'h13111d7f,
                               32'he3944a17, 32'hf307a78b, 32'h4d2b30c5};
    run_key(0, K1, lat);
    n_checks++;
    if (lat !== 41) begin n_fail++; $display("FAIL lat128: got %0d expected 41", lat); end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (wword(0, idx_t[k]) !== exp_t[k]) begin
        n_fail++; $display("FAIL aes128a_w%0d: got %h expected %h", idx_t[k], wword(0, idx_t[k]), exp_t[k]);
      end
    end
    n_checks++;
    if (ir !== 1'b0 || bz !== 1'b0) begin
      n_fail++; $display("FAIL done_flags128: in_ready=%b busy=%b expected 0/0", ir, bz);
    end
    handshake(0);
  endtask

  task automatic test_aes128_b();
    int lat;
    int idx_t [4] = '{4, 5, 6, 43};
    logic [31:0] exp_t [4] = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'hb6630ca6};
    run_key(0, K2, lat);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wword(0, idx_t[k]) !== exp_t[k]) begin
        n_fail++; $display("FAIL aes128b_w%0d: got %h expected %h", idx_t[k], wword(0, idx_t[k]), exp_t[k]);
      end
    end
    handshake(0);
  endtask

  task automatic test_aes192();
    int lat;
    int idx_t [3] = '{0, 6, 51};
    logic [31:0] exp_t [3] = '{32'h8e73b0f7, 32'hfe0c91f7, 32'h01002202};
    run_key(1, K3, lat);
    n_checks++;
    if (lat !== 47) begin n_fail++; $display("FAIL lat192: got %0d expected 47", lat); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wword(1, idx_t[k]) !== exp_t[k]) begin
        n_fail++; $display("FAIL aes192_w%0d: got %h expected %h", idx_t[k], wword(1, idx_t[k]), exp_t[k]);
      end
    end
    handshake(1);
  endtask

  task automatic test_aes256();
    int lat;
    int idx_t [4] = '{7, 8, 12, 59};
    logic [31:0] exp_t [4] = '{32'h0914dff4, 32'h9ba35411, 32'ha8b09c1a, 32'h706c631e};
    run_key(2, K4, lat);
    n_checks++;
    if (lat !== 53) begin n_fail++; $display("FAIL lat256: got %0d expected 53", lat); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wword(2, idx_t[k]) !== exp_t[k]) begin
        n_fail++; $display("FAIL aes256_w%0d: got %h expected %h", idx_t[k], wword(2, idx_t[k]), exp_t[k]);
      end
    end
    handshake(2);
  endtask

  // in_valid and out_ready pulses during EXPAND are ignored; DONE holds w
  task automatic test_done_hold();
    int cyc;
    sel = 0;
    @(negedge clk);
    k128 = K1[255:128]; v128 = 1'b1;
    @(negedge clk);
    v128 = 1'b0;
    k128 = 128'hffeeddccbbaa99887766554433221100;
    cyc = 1;
    while (ov !== 1'b1 && cyc < 200) begin
      n_checks++;
      if (bz !== 1'b1 || ov !== 1'b0 || ir !== 1'b0) begin
        n_fail++; $display("FAIL expand_flags c%0d: busy=%b out_valid=%b in_ready=%b expected 1/0/0",
                           cyc, bz, ov, ir);
      end
      if (cyc == 5) begin
        n_checks++;
        if (wword(0, 43) !== 32'h0) begin
          n_fail++; $display("FAIL unwritten_w43: got %h expected 00000000", wword(0, 43));
        end
      end
      v128 = (cyc == 10);
      r128 = (cyc == 12);
      @(negedge clk);
      cyc++;
    end
    v128 = 1'b0; r128 = 1'b0;
    n_checks++;
    if (cyc !== 41) begin n_fail++; $display("FAIL hold_lat: got %0d expected 41", cyc); end
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (ov !== 1'b1 || ir !== 1'b0 || wword(0, 40) !== 32'h13111d7f || wword(0, 43) !== 32'h4d2b30c5) begin
        n_fail++; $display("FAIL done_hold c%0d: out_valid=%b in_ready=%b w40=%h w43=%h expected 1/0/13111d7f/4d2b30c5",
                           c, ov, ir, wword(0, 40), wword(0, 43));
      end
      @(negedge clk);
    end
    handshake(0);
  endtask

  task automatic test_reset_mid();
    int lat;
    sel = 0;
    @(negedge clk);
    k128 = K1[255:128]; v128 = 1'b1;
    @(negedge clk);
    v128 = 1'b0;
    // after accept edge plus 16 more edges, idx = 4 + 16 = 20
    repeat (16) @(negedge clk);
    n_checks++;
    if (bz !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b expected 1", bz); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w128 !== '0 || ov !== 1'b0 || bz !== 1'b0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: w4=%h out_valid=%b busy=%b in_ready=%b expected 0/0/0/1",
                         wword(0, 4), ov, bz, ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_key(0, K2, lat);
    n_checks++;
    if (lat !== 41 || wword(0, 4) !== 32'ha0fafe17 || wword(0, 43) !== 32'hb6630ca6) begin
      n_fail++; $display("FAIL post_reset: lat=%0d w4=%h w43=%h expected 41/a0fafe17/b6630ca6",
                         lat, wword(0, 4), wword(0, 43));
    end
    handshake(0);
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int lat;
    run_key(0, K1, lat);
    @(negedge clk);
    z128 = 1'b1; r128 = 1'b1;
    @(negedge clk);
    z128 = 1'b0; r128 = 1'b0;
    n_checks++;
    if (w128 !== '0 || ov !== 1'b0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL zeroize_done: w43=%h out_valid=%b in_ready=%b expected 0/0/1",
                         wword(0, 43), ov, ir);
    end
    k128 = K2[255:128]; v128 = 1'b1; z128 = 1'b1;
    @(negedge clk);
    v128 = 1'b0; z128 = 1'b0;
    n_checks++;
    if (bz !== 1'b0 || ir !== 1'b1 || wword(0, 0) !== 32'h0) begin
      n_fail++; $display("FAIL zeroize_accept: busy=%b in_ready=%b w0=%h expected 0/1/0", bz, ir, wword(0, 0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_aes128_a();
    test_aes128_b();
    test_aes192();
    test_aes256();
    test_done_hold();
    test_reset_mid();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
